alu_mc: RTL and testbench

Parametrised multi-cycle ALU with valid/ready handshakes. It is the next generation of the 32-bit opcode-driven ALU. It replaces the bare `enable` strobe with flow-controlled input and output channels, generalises the datapath to `WIDTH` bits, registers its result and status flags, and adds iterative multiply and divide. It sits between the decode stage and writeback.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_muldiv.sv | 74 +++++++
 rtl/alu_mc.sv | 154 +++++++++++++++
 tb/tb_alu_mc.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag bundle for the multi-cycle ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_OR   = 5'h03;
  localparam logic [4:0] OP_XOR  = 5'h04;
  localparam logic [4:0] OP_NOT  = 5'h05;
  localparam logic [4:0] OP_SLL  = 5'h06;
  localparam logic [4:0] OP_SRL  = 5'h07;
  localparam logic [4:0] OP_SRA  = 5'h08;
  localparam logic [4:0] OP_SLT  = 5'h09;
  localparam logic [4:0] OP_SLTU = 5'h0A;
  localparam logic [4:0] OP_PASS = 5'h0B;
  localparam logic [4:0] OP_MUL  = 5'h10;
  localparam logic [4:0] OP_DIVU = 5'h11;
  localparam logic [4:0] OP_REMU = 5'h12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
    logic err;
  } flags_t;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unit: shift-add multiply (low half) and restoring unsigned divide.
// One step per cycle for WIDTH cycles; done_c/result_c accompany the final step.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_c,
  output logic [WIDTH-1:0] result_c
);

  localparam int unsigned CW  = $clog2(WIDTH) + 1;
  localparam int unsigned MSB = WIDTH - 1;

  logic             active;
  logic [CW-1:0]    cnt;
  logic [4:0]       op_q;
  // acc: product or remainder; xr: multiplicand or dividend/quotient; yr: multiplier or divisor
  logic [WIDTH-1:0] acc, xr, yr;
  logic [WIDTH-1:0] acc_n, xr_n, yr_n;
  logic [WIDTH:0]   rem_sh;

  always_comb begin
    rem_sh = {acc, xr[MSB]};
    acc_n  = acc;
    xr_n   = xr;
    yr_n   = yr;
    if (op_q == OP_MUL) begin
      acc_n = yr[0] ? acc + xr : acc;
      xr_n  = {xr[WIDTH-2:0], 1'b0};
      yr_n  = {1'b0, yr[WIDTH-1:1]};
    end else if (rem_sh >= {1'b0, yr}) begin
      acc_n = WIDTH'(rem_sh - {1'b0, yr});
      xr_n  = {xr[WIDTH-2:0], 1'b1};
    end else begin
      acc_n = rem_sh[WIDTH-1:0];
      xr_n  = {xr[WIDTH-2:0], 1'b0};
    end
  end

  assign done_c   = active && (cnt == CW'(WIDTH - 1));
  assign result_c = (op_q == OP_DIVU) ? xr_n : acc_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      op_q   <= '0;
      acc    <= '0;
      xr     <= '0;
      yr     <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      op_q   <= op;
      acc    <= '0;
      xr     <= a;
      yr     <= b;
    end else if (active) begin
      acc <= acc_n;
      xr  <= xr_n;
      yr  <= yr_n;
      cnt <= cnt + CW'(1);
      if (done_c) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready in/out channels and registered result/flags.
// Build with ALU_MULDIV_EN defined to add MUL/DIVU/REMU via alu_muldiv.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err
);

  localparam int unsigned MSB = WIDTH - 1;

  state_t           state, nxt_state;
  logic [WIDTH-1:0] out_q, nxt_out, sc_res;
  flags_t           flg_q, nxt_flg, sc_flg;
  logic [WIDTH:0]   add_w, sub_w;
  logic [SHW-1:0]   sh;
  logic             accept, take;

  assign in_ready  = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign out       = out_q;
  assign flag_z    = flg_q.z;
  assign flag_n    = flg_q.n;
  assign flag_c    = flg_q.c;
  assign flag_v    = flg_q.v;
  assign err       = flg_q.err;

  // Single-cycle datapath; anything not decoded here is illegal.
  always_comb begin
    add_w  = {1'b0, a} + {1'b0, b};
    sub_w  = {1'b0, a} - {1'b0, b};
    sh     = b[SHW-1:0];
    sc_res = '0;
    sc_flg = '0;
    case (opcode)
      OP_ADD: begin
        sc_res   = add_w[WIDTH-1:0];
        sc_flg.c = add_w[WIDTH];
        sc_flg.v = (a[MSB] == b[MSB]) && (add_w[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sc_res   = sub_w[WIDTH-1:0];
        sc_flg.c = !sub_w[WIDTH];
        sc_flg.v = (a[MSB] != b[MSB]) && (sub_w[MSB] != a[MSB]);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOT:  sc_res = ~a;
      OP_SLL:  sc_res = a << sh;
      OP_SRL:  sc_res = a >> sh;
      OP_SRA:  sc_res = WIDTH'($signed(a) >>> sh);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_PASS: sc_res = b;
      default: sc_flg.err = 1'b1;
    endcase
    if (!sc_flg.err) begin
      sc_flg.z = (sc_res == '0);
      sc_flg.n = sc_res[MSB];
    end
  end

`ifdef ALU_MULDIV_EN
  logic             md_start, is_md, md_done_c;
  logic [WIDTH-1:0] md_result_c;

  assign is_md = (opcode == OP_MUL) || (opcode == OP_DIVU) || (opcode == OP_REMU);

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start    (md_start),
    .op       (opcode),
    .a        (a),
    .b        (b),
    .done_c   (md_done_c),
    .result_c (md_result_c)
  );
`endif

  // Next-state and next-result selection.
  always_comb begin
    nxt_state = state;
    nxt_out   = out_q;
    nxt_flg   = flg_q;
    take      = 1'b0;
`ifdef ALU_MULDIV_EN
    md_start  = 1'b0;
`endif
    case (state)
      ST_IDLE: take = accept;
      ST_DONE: begin
        if (out_ready) nxt_state = ST_IDLE;
        take = accept;
      end
`ifdef ALU_MULDIV_EN
      ST_BUSY: begin
        if (md_done_c) begin
          nxt_state = ST_DONE;
          nxt_out   = md_result_c;
          nxt_flg   = '0;
          nxt_flg.z = (md_result_c == '0);
          nxt_flg.n = md_result_c[MSB];
        end
      end
`endif
      default: nxt_state = ST_IDLE;
    endcase
    if (take) begin
`ifdef ALU_MULDIV_EN
      if (is_md) begin
        nxt_state = ST_BUSY;
        md_start  = 1'b1;
      end else
`endif
      begin
        nxt_state = ST_DONE;
        nxt_out   = sc_res;
        nxt_flg   = sc_flg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      out_q <= '0;
      flg_q <= '0;
    end else begin
      state <= nxt_state;
      out_q <= nxt_out;
      flg_q <= nxt_flg;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=32).
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  opcode;
  logic [31:0] a, b, out;
  logic        flag_z, flag_n, flag_c, flag_v, err;

  int checks = 0;
  int failures = 0;
  int lat, rdy_busy;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .flag_v(flag_v), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // flags packed as {z,n,c,v,err}
  task automatic chk_res(input string tag, input logic [31:0] eo, input logic [4:0] ef);
    chk({tag, "_out"}, out, eo);
    chk({tag, "_flg"}, 32'({flag_z, flag_n, flag_c, flag_v, err}), 32'(ef));
  endtask

  // Offer one op (entered at posedge+1), scramble inputs after accept, wait for out_valid.
  task automatic run_op(input logic [4:0] op, input logic [31:0] aa, input logic [31:0] bb,
                        output int l, output int rb);
    in_valid = 1'b1; opcode = op; a = aa; b = bb;
    #1;
    chk("accept_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; opcode = 5'($urandom); a = $urandom; b = $urandom;
    l = 1; rb = 0;
    while (!out_valid && l < 200) begin
      if (in_ready) rb++;
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("consume_idle", 32'(out_valid), 32'd0);
  endtask

  task automatic single(input string tag, input logic [4:0] op, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [31:0] eo, input logic [4:0] ef);
    int l, rb;
    run_op(op, aa, bb, l, rb);
    chk({tag, "_lat"}, 32'(l), 32'd1);
    chk_res(tag, eo, ef);
    consume();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opcode = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk_res("rst", 32'h0, 5'b00000);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    //                      op       a             b             out           zncve
    single("add_plain",  5'h00, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h1E1E1E1E, 5'b00000);
    single("add_wrap",   5'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10100);
    single("sub_ovf",    5'h01, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b00110);
    single("sub_borrow", 5'h01, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 5'b01000);
    single("sub_eq",     5'h01, 32'h00000003, 32'h00000003, 32'h00000000, 5'b10100);
    single("and",        5'h02, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b01000);
    single("or",         5'h03, 32'h0F0F0000, 32'h00F000F0, 32'h0FFF00F0, 5'b00000);
    single("xor",        5'h04, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 5'b00000);
    single("not",        5'h05, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 5'b01000);
    single("sll_mod",    5'h06, 32'h00000001, 32'h00000021, 32'h00000002, 5'b00000);
    single("srl",        5'h07, 32'h80000000, 32'h0000001F, 32'h00000001, 5'b00000);
    single("sra",        5'h08, 32'h80000000, 32'h00000004, 32'hF8000000, 5'b01000);
    single("slt",        5'h09, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'b00000);
    single("sltu",       5'h0A, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10000);
    single("pass",       5'h0B, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 5'b00000);
    single("ill_1f",     5'h1F, 32'h00000005, 32'h00000006, 32'h00000000, 5'b00001);
    single("ill_0c",     5'h0C, 32'h00000005, 32'h00000006, 32'h00000000, 5'b00001);

`ifdef ALU_MULDIV_EN
    run_op(5'h10, 32'h0000FFFF, 32'h00010001, lat, rdy_busy);
    chk("mul_lat", 32'(lat), 32'd33);
    chk("mul_busy_rdy", 32'(rdy_busy), 32'd0);
    chk_res("mul", 32'hFFFFFFFF, 5'b01000);
    consume();
    run_op(5'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, rdy_busy);
    chk("mul2_lat", 32'(lat), 32'd33);
    chk_res("mul2", 32'h00000001, 5'b00000);
    consume();
    run_op(5'h11, 32'd100, 32'd0, lat, rdy_busy);
    chk("divz_lat", 32'(lat), 32'd33);
    chk_res("divz", 32'hFFFFFFFF, 5'b01000);
    consume();
    run_op(5'h12, 32'd100, 32'd0, lat, rdy_busy);
    chk_res("remz", 32'd100, 5'b00000);
    consume();
    run_op(5'h11, 32'd100, 32'd7, lat, rdy_busy);
    chk_res("divu", 32'd14, 5'b00000);
    consume();
    run_op(5'h12, 32'd100, 32'd7, lat, rdy_busy);
    chk_res("remu", 32'd2, 5'b00000);
    consume();
`else
    single("mul_ill",    5'h10, 32'h0000FFFF, 32'h00010001, 32'h00000000, 5'b00001);
    single("remu_ill",   5'h12, 32'h00000064, 32'h00000007, 32'h00000000, 5'b00001);
`endif

    // Backpressure: result held for 5 cycles, then back-to-back accept
    out_ready = 1'b0;
    run_op(5'h01, 32'd1, 32'd2, lat, rdy_busy);
    chk("bp_lat", 32'(lat), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk_res("bp_hold", 32'hFFFFFFFF, 5'b01000);
    end
    out_ready = 1'b1;
    run_op(5'h00, 32'd7, 32'd8, lat, rdy_busy);
    chk("b2b_lat", 32'(lat), 32'd1);
    chk_res("b2b", 32'd15, 5'b00000);
    consume();

    // Reset while DONE discards the result
    out_ready = 1'b0;
    run_op(5'h00, 32'd1, 32'd1, lat, rdy_busy);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_done_valid", 32'(out_valid), 32'd0);
    chk("rst_done_ready", 32'(in_ready), 32'd1);
    chk_res("rst_done", 32'h0, 5'b00000);
    @(posedge clk); #1;

`ifdef ALU_MULDIV_EN
    // Reset mid-BUSY, cycle 10 of a multiply
    in_valid = 1'b1; opcode = 5'h10; a = 32'h0000FFFF; b = 32'h00010001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_busy_valid", 32'(out_valid), 32'd0);
    chk("rst_busy_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
`endif
    single("add_after_rst", 5'h00, 32'd2, 32'd3, 32'd5, 5'b00000);
    repeat (40) @(posedge clk);
    #1;
    chk("quiet_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
